dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between two requesters:
//   - port 0: the CPU load/store unit.
//   - port 1: the debug/loader engine, which writes program data and peeks at memory.
//  Round-robin arbitration; the winner's request is forwarded to the data memory in the same cycle.
//  Read responses are routed back to their owner through a tag pipeline matching memory read latency.
//  Sits between the pipelined CPU / debug engine and the data memory, in the CPU clock domain.
// PARAMETERS
//  ALEN     32  address width
//  XLEN     32  data width
//  RD_LAT   1   memory read latency in cycles (>=1); depth of the response tag pipeline
//  CNT_W    16  width of the saturating conflict counter
// PORTS
//  clk            in   1     CPU clock; all state updates on rising edge
//  rst_n          in   1     synchronous reset, active low
//  p0_req/p1_req  in   1     request valid, one per port
//  pN_we          in   1     1 = store, 0 = load
//  pN_be          in   4     byte enables (store)
//  pN_funct3      in   3     access size/sign, forwarded to memory
//  pN_addr        in   ALEN  address
//  pN_wdata       in   XLEN  store data
//  pN_gnt         out  1     request accepted this cycle (combinational)
//  pN_rvalid      out  1     load data valid for port N (1-cycle pulse)
//  pN_rdata       out  XLEN  load data; equals mem_rdata, meaningful only with pN_rvalid
//  p0_stall       out  1     p0_req & ~p0_gnt; drives the CPU stall input
//  mem_we         out  1     to data memory
//  mem_be         out  4     to data memory
//  mem_funct3     out  3     to data memory
//  mem_addr       out  ALEN  to data memory
//  mem_wdata      out  XLEN  to data memory
//  mem_rdata      in   XLEN  from data memory, RD_LAT cycles after address
//  conflict_cnt   out  CNT_W cycles in which a requester was refused
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - last_gnt <= 1, so port 0 wins the first tie.
//   - tag pipeline cleared; conflict_cnt <= 0.
//   - While rst_n=0, pN_gnt, mem_we, pN_rvalid and p0_stall are forced to 0 combinationally.
//  Arbitration (each cycle, combinational):
//   - Only one port requesting: that port is granted.
//   - Both requesting: the port != last_gnt is granted.
//   - Neither requesting: no grant; mem_we=0, other mem_* outputs don't-care.
//   - At most one gnt per cycle.
//   - last_gnt updates on every grant; it holds when there is no grant.
//  Forwarding:
//   - mem_* outputs = the granted port's fields in the same cycle.
//   - mem_we = granted & pN_we.
//  Handshake:
//   - Requester holds req and payload stable until it sees gnt; it may change them the cycle after.
//   - The arbiter never retracts a grant.
//   - A granted store completes in the grant cycle and produces no rvalid.
//  Response pipeline:
//   - A granted load pushes {valid=1, id=N} into stage 0.
//   - Stages shift every cycle.
//   - At stage RD_LAT-1, valid raises pN_rvalid for exactly one cycle, aligned with mem_rdata.
//   - Fully pipelined: a new load may be granted every cycle. Accept and response for different
//     transactions may coincide, including both on the same port.
//  Conflict counter:
//   - Increments when (p0_req & p1_req), i.e. one port is refused.
//   - Saturates at 2^CNT_W-1 with no wrap.
//  Reset mid-operation: in-flight loads are discarded; no rvalid for them after reset releases.
//  Pending requests are re-arbitrated from last_gnt=1.
// TESTING
//  1. Reset held 3 cycles with both req=1 -> gnt=0, mem_we=0, rvalid=0; after release p0 wins
//     first, then p1.
//  2. p0 load addr 0x100 alone, RD_LAT=1 -> p0_gnt same cycle; p0_rvalid next cycle with data;
//     p1_rvalid stays 0.
//  3. Both req continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; conflict_cnt=6;
//     p0_stall high on cycles 2,4,6.
//  4. Back-to-back loads p0@0x10, p1@0x20, p0@0x30 -> rvalid pulses route to p0, p1, p0 on
//     consecutive cycles with the matching data.
//  5. p1 store 0xDEADBEEF be=4'b1111 @0x40, then p0 load @0x40 -> mem_we=1 only in the store
//     cycle; p0 reads 0xDEADBEEF; no rvalid for the store.
//  6. RD_LAT=2; issue a load, then drop rst_n the following cycle -> no rvalid ever seen;
//     conflict_cnt=0. Also force 2^CNT_W+3 conflicts -> counter holds at all-ones.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// ============================================================================
// Module : dmem_port_arbiter_if
// Brief  : Requester ports and data-memory port for the dmem port arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface dmem_port_arbiter_if #(
  parameter int ALEN  = 32,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  // port 0 : CPU load/store unit
  logic            p0_req;
  logic            p0_we;
  logic [3:0]      p0_be;
  logic [2:0]      p0_funct3;
  logic [ALEN-1:0] p0_addr;
  logic [XLEN-1:0] p0_wdata;
  logic            p0_gnt;
  logic            p0_rvalid;
  logic [XLEN-1:0] p0_rdata;
  logic            p0_stall;

  // port 1 : debug / loader engine
  logic            p1_req;
  logic            p1_we;
  logic [3:0]      p1_be;
  logic [2:0]      p1_funct3;
  logic [ALEN-1:0] p1_addr;
  logic [XLEN-1:0] p1_wdata;
  logic            p1_gnt;
  logic            p1_rvalid;
  logic [XLEN-1:0] p1_rdata;

  // data memory
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [2:0]      mem_funct3;
  logic [ALEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  logic [CNT_W-1:0] conflict_cnt;

  modport slave (
    input  p0_req, p0_we, p0_be, p0_funct3, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_be, p1_funct3, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_stall,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_we, mem_be, mem_funct3, mem_addr, mem_wdata,
    output conflict_cnt
  );

  modport master (
    output p0_req, p0_we, p0_be, p0_funct3, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_be, p1_funct3, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_stall,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_we, mem_be, mem_funct3, mem_addr, mem_wdata,
    input  conflict_cnt
  );
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module : dmem_port_arbiter
// Brief  : Round-robin sharing of one data-memory port between the CPU LSU
//          (port 0) and the debug/loader engine (port 1), with load-response
//          routing through a tag pipeline matched to memory read latency.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
  parameter int ALEN   = 32,
  parameter int XLEN   = 32,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_port_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic             r_last_gnt;
  logic [RD_LAT-1:0] r_tag_vld;
  logic [RD_LAT-1:0] r_tag_id;
  logic [CNT_W-1:0] r_conflict_cnt;

  logic w_gnt0;
  logic w_gnt1;
  logic w_both;
  logic w_load;

  // A tie goes to the port that did not win last time.
  assign w_both = bus.p0_req & bus.p1_req;
  assign w_gnt0 = rst_n & bus.p0_req & (~bus.p1_req | r_last_gnt);
  assign w_gnt1 = rst_n & bus.p1_req & (~bus.p0_req | ~r_last_gnt);
  assign w_load = (w_gnt0 & ~bus.p0_we) | (w_gnt1 & ~bus.p1_we);

  always_comb begin
    bus.mem_we     = 1'b0;
    bus.mem_be     = bus.p0_be;
    bus.mem_funct3 = bus.p0_funct3;
    bus.mem_addr   = bus.p0_addr;
    bus.mem_wdata  = bus.p0_wdata;
    if (w_gnt1) begin
      bus.mem_we     = bus.p1_we;
      bus.mem_be     = bus.p1_be;
      bus.mem_funct3 = bus.p1_funct3;
      bus.mem_addr   = bus.p1_addr;
      bus.mem_wdata  = bus.p1_wdata;
    end else if (w_gnt0) begin
      bus.mem_we = bus.p0_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_gnt <= 1'b1;
    end else if (w_gnt0) begin
      r_last_gnt <= 1'b0;
    end else if (w_gnt1) begin
      r_last_gnt <= 1'b1;
    end
  end

  // Stage 0 captures the granted load; the last stage lines up with mem_rdata.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld[0] <= w_load;
      r_tag_id[0]  <= w_gnt1;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_id[i]  <= r_tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_both && (r_conflict_cnt != C_CNT_MAX)) begin
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign bus.p0_gnt       = w_gnt0;
  assign bus.p1_gnt       = w_gnt1;
  assign bus.p0_stall     = rst_n & bus.p0_req & ~w_gnt0;
  assign bus.p0_rvalid    = rst_n & r_tag_vld[RD_LAT-1] & ~r_tag_id[RD_LAT-1];
  assign bus.p1_rvalid    = rst_n & r_tag_vld[RD_LAT-1] &  r_tag_id[RD_LAT-1];
  assign bus.p0_rdata     = bus.mem_rdata;
  assign bus.p1_rdata     = bus.mem_rdata;
  assign bus.conflict_cnt = r_conflict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
// Module : tb_dmem_port_arbiter
// Brief  : Self-checking bench: vector table, directed sequences, random run.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_port_arbiter;

  localparam int RD_LAT_A = 1;
  localparam int RD_LAT_B = 2;
  localparam int CNT_W_A  = 16;
  localparam int CNT_W_B  = 4;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ALEN(32), .XLEN(32), .CNT_W(CNT_W_A)) bus_a ();
  dmem_port_arbiter_if #(.ALEN(32), .XLEN(32), .CNT_W(CNT_W_B)) bus_b ();

  dmem_port_arbiter #(.ALEN(32), .XLEN(32), .RD_LAT(RD_LAT_A), .CNT_W(CNT_W_A)) u_dut_a (
    .clk(clk), .rst_n(rst_a_n), .bus(bus_a.slave));
  dmem_port_arbiter #(.ALEN(32), .XLEN(32), .RD_LAT(RD_LAT_B), .CNT_W(CNT_W_B)) u_dut_b (
    .clk(clk), .rst_n(rst_b_n), .bus(bus_b.slave));

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] word_init(int idx);
    return 32'hC0DE_0000 | idx;
  endfunction

  // Data memories: A has one cycle of read latency, B has two and is read-only.
  logic [31:0] mem_a [int];
  logic [31:0] b_d1;
  always @(posedge clk) begin
    int idx;
    logic [31:0] w;
    idx = int'(bus_a.mem_addr[9:2]);
    bus_a.mem_rdata <= mem_a.exists(idx) ? mem_a[idx] : word_init(idx);
    if (bus_a.mem_we) begin
      w = mem_a.exists(idx) ? mem_a[idx] : word_init(idx);
      for (int b = 0; b < 4; b++)
        if (bus_a.mem_be[b]) w[8*b +: 8] = bus_a.mem_wdata[8*b +: 8];
      mem_a[idx] = w;
    end
  end
  always @(posedge clk) begin
    b_d1            <= word_init(int'(bus_b.mem_addr[9:2]));
    bus_b.mem_rdata <= b_d1;
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model for instance A ----------------
  typedef struct { int due; int port; logic [31:0] data; } resp_t;
  resp_t       pend[$];
  logic [31:0] ref_mem [int];
  int          m_cycle = 0;
  int          m_last  = 1;
  int          m_cnt   = 0;
  int          cur_winner = -1;

  function automatic logic [31:0] ref_read(int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : word_init(idx);
  endfunction

  task automatic eval_a();
    bit r0, r1, ev0, ev1, exp_we;
    logic [31:0] ed0, ed1;
    int winner;
    @(negedge clk);
    r0 = bus_a.p0_req;
    r1 = bus_a.p1_req;
    winner = -1;
    if (rst_a_n) begin
      if (r0 && r1)  winner = (m_last == 0) ? 1 : 0;
      else if (r0)   winner = 0;
      else if (r1)   winner = 1;
    end
    chk("gnt0",  bus_a.p0_gnt,   winner == 0);
    chk("gnt1",  bus_a.p1_gnt,   winner == 1);
    chk("stall", bus_a.p0_stall, rst_a_n && r0 && winner != 0);
    exp_we = (winner == 0) ? bus_a.p0_we : (winner == 1) ? bus_a.p1_we : 1'b0;
    chk("mem_we", bus_a.mem_we, exp_we);
    if (winner == 0) begin
      chk("mem_addr",  bus_a.mem_addr,  bus_a.p0_addr);
      chk("mem_wdata", bus_a.mem_wdata, bus_a.p0_wdata);
      chk("mem_be_f3", {bus_a.mem_be, bus_a.mem_funct3}, {bus_a.p0_be, bus_a.p0_funct3});
    end else if (winner == 1) begin
      chk("mem_addr",  bus_a.mem_addr,  bus_a.p1_addr);
      chk("mem_wdata", bus_a.mem_wdata, bus_a.p1_wdata);
      chk("mem_be_f3", {bus_a.mem_be, bus_a.mem_funct3}, {bus_a.p1_be, bus_a.p1_funct3});
    end
    ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0;
    if (rst_a_n)
      foreach (pend[i])
        if (pend[i].due == m_cycle) begin
          if (pend[i].port == 0) begin ev0 = 1; ed0 = pend[i].data; end
          else                   begin ev1 = 1; ed1 = pend[i].data; end
        end
    chk("rvalid0", bus_a.p0_rvalid, ev0);
    chk("rvalid1", bus_a.p1_rvalid, ev1);
    if (ev0) chk("rdata0", bus_a.p0_rdata, ed0);
    if (ev1) chk("rdata1", bus_a.p1_rdata, ed1);
    chk("conflict_cnt", bus_a.conflict_cnt, m_cnt);
    cur_winner = winner;
  endtask

  task automatic advance_a();
    logic [31:0] addr, wd, w;
    logic [3:0]  be;
    bit          we;
    int          idx;
    if (!rst_a_n) begin
      pend.delete();
      m_last = 1;
      m_cnt  = 0;
    end else begin
      if (bus_a.p0_req && bus_a.p1_req && m_cnt < (1 << CNT_W_A) - 1) m_cnt++;
      if (cur_winner >= 0) begin
        addr = (cur_winner == 0) ? bus_a.p0_addr  : bus_a.p1_addr;
        wd   = (cur_winner == 0) ? bus_a.p0_wdata : bus_a.p1_wdata;
        be   = (cur_winner == 0) ? bus_a.p0_be    : bus_a.p1_be;
        we   = (cur_winner == 0) ? bus_a.p0_we    : bus_a.p1_we;
        idx  = int'(addr[9:2]);
        if (we) begin
          w = ref_read(idx);
          for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
          ref_mem[idx] = w;
        end else begin
          pend.push_back('{m_cycle + RD_LAT_A, cur_winner, ref_read(idx)});
        end
        m_last = cur_winner;
      end
      while (pend.size() > 0 && pend[0].due <= m_cycle) pend.delete(0);
    end
    @(posedge clk);
    m_cycle++;
    #1;
  endtask

  task automatic set_p(int p, bit req, bit we, logic [31:0] addr, logic [31:0] wd,
                       logic [3:0] be, logic [2:0] f3);
    if (p == 0) begin
      bus_a.p0_req = req; bus_a.p0_we = we; bus_a.p0_addr = addr;
      bus_a.p0_wdata = wd; bus_a.p0_be = be; bus_a.p0_funct3 = f3;
    end else begin
      bus_a.p1_req = req; bus_a.p1_we = we; bus_a.p1_addr = addr;
      bus_a.p1_wdata = wd; bus_a.p1_be = be; bus_a.p1_funct3 = f3;
    end
  endtask

  task automatic rand_port(int p);
    set_p(p, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          {22'd0, 8'($urandom), 2'b00}, $urandom, 4'($urandom_range(1, 15)),
          3'($urandom));
  endtask

  task automatic do_reset_a();
    set_p(0, 0, 0, 0, 0, 4'hF, 3'b010);
    set_p(1, 0, 0, 0, 0, 4'hF, 3'b010);
    rst_a_n = 1'b0;
    eval_a();
    advance_a();
    rst_a_n = 1'b1;
  endtask

  typedef struct {
    bit r0, r1, we0, we1;
    logic [31:0] a0, a1;
    bit g0, g1, mwe, st, ca;
    logic [31:0] maddr;
  } vec_t;
  vec_t vecs [9];

  initial begin
    vecs[0] = '{1,0,0,0, 32'h100, 32'h000, 1,0,0,0, 1, 32'h100};
    vecs[1] = '{1,1,0,0, 32'h104, 32'h200, 0,1,0,1, 1, 32'h200};
    vecs[2] = '{1,1,0,0, 32'h104, 32'h204, 1,0,0,0, 1, 32'h104};
    vecs[3] = '{0,0,0,0, 32'h000, 32'h000, 0,0,0,0, 0, 32'h000};
    vecs[4] = '{0,1,0,1, 32'h000, 32'h208, 0,1,1,0, 1, 32'h208};
    vecs[5] = '{1,1,1,0, 32'h10C, 32'h20C, 1,0,1,0, 1, 32'h10C};
    vecs[6] = '{0,1,0,0, 32'h000, 32'h20C, 0,1,0,0, 1, 32'h20C};
    vecs[7] = '{1,1,0,0, 32'h110, 32'h210, 1,0,0,0, 1, 32'h110};
    vecs[8] = '{0,1,0,0, 32'h000, 32'h210, 0,1,0,0, 1, 32'h210};

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    set_p(0, 0, 0, 0, 0, 4'hF, 3'b010);
    set_p(1, 0, 0, 0, 0, 4'hF, 3'b010);
    bus_b.p0_req = 0; bus_b.p0_we = 0; bus_b.p0_be = 4'hF; bus_b.p0_funct3 = 3'b010;
    bus_b.p0_addr = 0; bus_b.p0_wdata = 0;
    bus_b.p1_req = 0; bus_b.p1_we = 0; bus_b.p1_be = 4'hF; bus_b.p1_funct3 = 3'b010;
    bus_b.p1_addr = 0; bus_b.p1_wdata = 0;
    @(posedge clk);
    #1;

    // Reset held with both requesting, then p0 wins first
    set_p(0, 1, 0, 32'h10, 0, 4'hF, 3'b010);
    set_p(1, 1, 0, 32'h20, 0, 4'hF, 3'b010);
    repeat (3) begin
      eval_a();
      chk("t1_rst_gnt", {bus_a.p0_gnt, bus_a.p1_gnt}, 2'b00);
      chk("t1_rst_we_rv", {bus_a.mem_we, bus_a.p0_rvalid, bus_a.p1_rvalid, bus_a.p0_stall}, 4'b0);
      advance_a();
    end
    rst_a_n = 1'b1;
    eval_a();
    chk("t1_first_p0", {bus_a.p0_gnt, bus_a.p1_gnt}, 2'b10);
    advance_a();
    set_p(0, 0, 0, 0, 0, 4'hF, 3'b010);
    eval_a();
    chk("t1_then_p1", {bus_a.p0_gnt, bus_a.p1_gnt}, 2'b01);
    advance_a();
    set_p(1, 0, 0, 0, 0, 4'hF, 3'b010);

    // Single p0 load
    do_reset_a();
    set_p(0, 1, 0, 32'h100, 0, 4'hF, 3'b010);
    eval_a();
    chk("t2_gnt", bus_a.p0_gnt, 1'b1);
    advance_a();
    set_p(0, 0, 0, 0, 0, 4'hF, 3'b010);
    eval_a();
    chk("t2_rvalid0", bus_a.p0_rvalid, 1'b1);
    chk("t2_rdata0", bus_a.p0_rdata, word_init(32'h40));
    chk("t2_rvalid1", bus_a.p1_rvalid, 1'b0);
    advance_a();

    // Continuous contention for 6 cycles
    do_reset_a();
    set_p(0, 1, 0, 32'h300, 0, 4'hF, 3'b010);
    set_p(1, 1, 0, 32'h380, 0, 4'hF, 3'b010);
    for (int k = 0; k < 6; k++) begin
      eval_a();
      chk("t3_gnt", {bus_a.p0_gnt, bus_a.p1_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("t3_stall", bus_a.p0_stall, k % 2);
      advance_a();
      if (k % 2 == 0) set_p(0, 1, 0, 32'h300 + 4 * (k + 1), 0, 4'hF, 3'b010);
      else            set_p(1, 1, 0, 32'h380 + 4 * (k + 1), 0, 4'hF, 3'b010);
    end
    set_p(0, 0, 0, 0, 0, 4'hF, 3'b010);
    set_p(1, 0, 0, 0, 0, 4'hF, 3'b010);
    eval_a();
    chk("t3_cnt", bus_a.conflict_cnt, 6);
    advance_a();

    // Back-to-back loads on alternating ports
    set_p(0, 1, 0, 32'h10, 0, 4'hF, 3'b010);
    eval_a(); advance_a();
    set_p(0, 0, 0, 0, 0, 4'hF, 3'b010);
    set_p(1, 1, 0, 32'h20, 0, 4'hF, 3'b010);
    eval_a();
    chk("t4_rv_a", {bus_a.p0_rvalid, bus_a.p1_rvalid}, 2'b10);
    chk("t4_rd_a", bus_a.p0_rdata, word_init(4));
    advance_a();
    set_p(1, 0, 0, 0, 0, 4'hF, 3'b010);
    set_p(0, 1, 0, 32'h30, 0, 4'hF, 3'b010);
    eval_a();
    chk("t4_rv_b", {bus_a.p0_rvalid, bus_a.p1_rvalid}, 2'b01);
    chk("t4_rd_b", bus_a.p1_rdata, word_init(8));
    advance_a();
    set_p(0, 0, 0, 0, 0, 4'hF, 3'b010);
    eval_a();
    chk("t4_rv_c", {bus_a.p0_rvalid, bus_a.p1_rvalid}, 2'b10);
    chk("t4_rd_c", bus_a.p0_rdata, word_init(12));
    advance_a();

    // Store through p1, read back through p0
    set_p(1, 1, 1, 32'h40, 32'hDEADBEEF, 4'b1111, 3'b010);
    eval_a();
    chk("t5_store_we", bus_a.mem_we, 1'b1);
    advance_a();
    set_p(1, 0, 0, 0, 0, 4'hF, 3'b010);
    set_p(0, 1, 0, 32'h40, 0, 4'hF, 3'b010);
    eval_a();
    chk("t5_load_we", bus_a.mem_we, 1'b0);
    chk("t5_no_store_rv", {bus_a.p0_rvalid, bus_a.p1_rvalid}, 2'b00);
    advance_a();
    set_p(0, 0, 0, 0, 0, 4'hF, 3'b010);
    eval_a();
    chk("t5_rv", {bus_a.p0_rvalid, bus_a.p1_rvalid}, 2'b10);
    chk("t5_rdata", bus_a.p0_rdata, 32'hDEADBEEF);
    advance_a();

    // Vector table
    do_reset_a();
    for (int i = 0; i < 9; i++) begin
      set_p(0, vecs[i].r0, vecs[i].we0, vecs[i].a0, 32'h1111_0000 + i, 4'hF, 3'b010);
      set_p(1, vecs[i].r1, vecs[i].we1, vecs[i].a1, 32'h2222_0000 + i, 4'hF, 3'b010);
      eval_a();
      chk("vec_gnt", {bus_a.p0_gnt, bus_a.p1_gnt}, {vecs[i].g0, vecs[i].g1});
      chk("vec_we_stall", {bus_a.mem_we, bus_a.p0_stall}, {vecs[i].mwe, vecs[i].st});
      if (vecs[i].ca) chk("vec_addr", bus_a.mem_addr, vecs[i].maddr);
      advance_a();
    end

    // Random traffic with occasional resets against the model
    rand_port(0);
    rand_port(1);
    for (int c = 0; c < 3000; c++) begin
      rst_a_n = ($urandom_range(0, 99) != 0);
      eval_a();
      advance_a();
      if (cur_winner == 0 || !bus_a.p0_req) rand_port(0);
      if (cur_winner == 1 || !bus_a.p1_req) rand_port(1);
    end
    rst_a_n = 1'b1;
    set_p(0, 0, 0, 0, 0, 4'hF, 3'b010);
    set_p(1, 0, 0, 0, 0, 4'hF, 3'b010);
    repeat (3) begin eval_a(); advance_a(); end

    // Instance B: two-cycle latency, reset discard, counter saturation
    rst_b_n = 1'b1;
    bus_b.p0_req = 1; bus_b.p0_addr = 32'h8;
    @(negedge clk);
    chk("b_gnt", bus_b.p0_gnt, 1'b1);
    @(posedge clk); #1;
    bus_b.p0_req = 0;
    @(negedge clk);
    chk("b_rv_early", bus_b.p0_rvalid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_rv_lat2", bus_b.p0_rvalid, 1'b1);
    chk("b_rdata", bus_b.p0_rdata, word_init(2));
    @(posedge clk); #1;
    bus_b.p0_req = 1;
    @(negedge clk);
    chk("b_gnt2", bus_b.p0_gnt, 1'b1);
    @(posedge clk); #1;
    bus_b.p0_req = 0;
    rst_b_n = 1'b0;
    @(negedge clk);
    chk("b_rst_rv", {bus_b.p0_rvalid, bus_b.p1_rvalid}, 2'b00);
    @(posedge clk); #1;
    rst_b_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("b_discard_rv", {bus_b.p0_rvalid, bus_b.p1_rvalid}, 2'b00);
      @(posedge clk); #1;
    end
    chk("b_cnt_zero", bus_b.conflict_cnt, 0);
    bus_b.p0_req = 1;
    bus_b.p1_req = 1;
    for (int k = 1; k <= (1 << CNT_W_B) + 3; k++) begin
      @(posedge clk); #1;
      if (k == (1 << CNT_W_B) - 2) chk("b_cnt_pre_sat", bus_b.conflict_cnt, 14);
    end
    chk("b_cnt_sat", bus_b.conflict_cnt, 15);
    bus_b.p0_req = 0;
    bus_b.p1_req = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
